dmem_responder: RTL

//  Multi-cycle data-memory responder: the memory-side end of the MIPS data-memory interface.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the MEM stage and the memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misaligned;

  // Processor side: issues requests, observes stall and the response.
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  stall, resp_valid, rdata, misaligned
  );

  // Memory side: accepts requests, produces stall and the response.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output stall, resp_valid, rdata, misaligned
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder. One load/store at a time: the request is
// captured in IDLE, waits LATENCY cycles in BUSY (the access happens on the last
// BUSY edge), then RESP pulses resp_valid for one cycle. stall freezes the
// pipeline from the cycle the request is first seen until the access completes.
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 3
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             cap_write;
  logic [AW+1:0]    cap_addr;
  logic [31:0]      cap_wdata;
  logic [31:0]      rdata_r;
  logic             mis_r;
  logic             stall_c;
  logic             resp_c;
  logic             accept;
  logic             access;
  logic             aligned;
  logic [AW-1:0]    cap_idx;
  logic [31:0]      ram [DEPTH];

  // Address bits above the word index alias onto the same RAM words.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.req_addr[31:AW+2]};

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign access  = (state_q == BUSY) && (cnt == '0);
  assign aligned = (cap_addr[1:0] == 2'b00);
  assign cap_idx = cap_addr[AW+1:2];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; RESP never samples req_valid.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    resp_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_c = bus.req_valid;
        if (bus.req_valid) state_d = BUSY;
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt == '0) state_d = RESP;
      end
      RESP: begin
        resp_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counter, load data and sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      rdata_r <= '0;
      mis_r   <= 1'b0;
    end else begin
      if (accept)                               cnt <= CNT_INIT;
      else if (state_q == BUSY && cnt != '0)    cnt <= cnt - CNT_W'(1);
      if (access) begin
        if (!cap_write) rdata_r <= aligned ? ram[cap_idx] : 32'h0;
        if (!aligned)   mis_r   <= 1'b1;
      end
    end
  end

  // Request capture; inputs are ignored once the access is in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write <= bus.req_write;
      cap_addr  <= bus.req_addr[AW+1:0];
      cap_wdata <= bus.req_wdata;
    end
  end

  // Word RAM; a misaligned store leaves it untouched.
  always_ff @(posedge clk) begin
    if (access && cap_write && aligned) ram[cap_idx] <= cap_wdata;
  end

  assign bus.stall      = stall_c;
  assign bus.resp_valid = resp_c;
  assign bus.rdata      = rdata_r;
  assign bus.misaligned = mis_r;
endmodule
